mips_boot_loader: RTL

- Streams a boot image into the Mips32 core's storage at power-up: instruction memory, data memory and register file.
- Replaces simulation-only memory preloading with a synthesizable loader fed by a valid/ready word stream (UART/JTAG bridge or bench).
- Decodes record headers and writes data words to the selected target with checksum protection.
- Holds the core in halt until a valid end-of-image record is received.

---
 rtl/mips_boot_pkg.sv | 24 ++
 rtl/mips_boot_loader_if.sv | 28 ++
 rtl/boot_record_checker.sv | 38 +++
 rtl/mips_boot_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the boot loader.
//   boot_state_t : loader FSM states
//   ERR_*        : err_code encodings
//   TGT_*        : write-target indices (bit position in wr_en)
package mips_boot_pkg;

  typedef enum logic [2:0] {
    StHdr,
    StAddr,
    StData,
    StCsum,
    StRun,
    StErr
  } boot_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TGT  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  localparam int unsigned TGT_IM  = 0;
  localparam int unsigned TGT_DM  = 1;
  localparam int unsigned TGT_REG = 2;

endpackage

// File: rtl/mips_boot_loader_if.sv
// Boot stream and storage write bus.
//   in_valid/in_data/in_ready : valid/ready word stream into the loader
//   wr_en/wr_addr/wr_data     : one-hot write port out to IM/DM/REG
// slave = loader side, master = stream source / storage side.
interface mips_boot_loader_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned NUM_TARGETS = 3
) ();

  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic                   in_ready;
  logic [NUM_TARGETS-1:0] wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/boot_record_checker.sv
// Running modulo-2^DATA_W sum of a record's data words.
//   clear_i      : zero the sum (wins over add_i)
//   add_i/data_i : accumulate data_i
//   check_data_i : candidate checksum; match_o = (sum == check_data_i)
module boot_record_checker #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] check_data_i,
  output logic              match_o
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match_o = (sum_q == check_data_i);

endmodule

// File: rtl/mips_boot_loader.sv
// Boot image loader: decodes HDR/ADDR/DATA/CSUM records from a word stream
// and writes data words into IM/DM/REG, releasing the core on end-of-image.
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : input stream and one-hot storage write port
//   restart      : sync pulse, abandon image and return to header decode
//   cpu_run      : image loaded and verified
//   err/err_code : sticky error and cause
//   words_loaded : saturating count of write pulses since reset/restart
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned NUM_TARGETS = 3,
  parameter int unsigned TGT_W       = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mips_boot_loader_if.slave   bus,
  input  logic                restart,
  output logic                cpu_run,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [31:0]         words_loaded
);

  boot_state_t state_q, state_d;
  logic [TGT_W-1:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   rdy_q, rdy_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [31:0]            words_q, words_d;
  // Stage 1 holds an accepted data word; stage 2 drives the write port.
  logic                   s1_vld_q, s1_vld_d;
  logic [TGT_W-1:0]       s1_tgt_q, s1_tgt_d;
  logic [ADDR_W-1:0]      s1_addr_q, s1_addr_d;
  logic [DATA_W-1:0]      s1_data_q, s1_data_d;
  logic [NUM_TARGETS-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;

  logic             xfer, csum_clear, csum_add, csum_match;
  logic [TGT_W-1:0] hdr_tgt;
  logic [CNT_W-1:0] hdr_cnt;

  // restart drops any concurrent stream word
  assign xfer    = bus.in_valid && rdy_q && !restart;
  assign hdr_tgt = bus.in_data[DATA_W-1 -: TGT_W];
  assign hdr_cnt = bus.in_data[CNT_W-1:0];

  boot_record_checker #(
    .DATA_W (DATA_W)
  ) u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (csum_clear),
    .add_i        (csum_add),
    .data_i       (bus.in_data),
    .check_data_i (bus.in_data),
    .match_o      (csum_match)
  );

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    err_code_d = err_code_q;
    s1_vld_d   = 1'b0;
    s1_tgt_d   = s1_tgt_q;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    csum_clear = 1'b0;
    csum_add   = 1'b0;
    wr_en_d    = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    words_d    = ((wr_en_q != '0) && (words_q != '1)) ? words_q + 32'd1 : words_q;

    if (s1_vld_q) begin
      wr_en_d   = NUM_TARGETS'(1) << s1_tgt_q;
      wr_addr_d = s1_addr_q;
      wr_data_d = s1_data_q;
    end

    if (restart) begin
      state_d    = StHdr;
      err_code_d = ERR_NONE;
      words_d    = '0;
      wr_en_d    = '0;
      csum_clear = 1'b1;
    end else if (xfer) begin
      unique case (state_q)
        StHdr: begin
          if (hdr_cnt == '0) begin
            state_d = StRun;
          end else if (32'(hdr_tgt) >= NUM_TARGETS) begin
            err_code_d = ERR_TGT;
            state_d    = StErr;
          end else begin
            tgt_d      = hdr_tgt;
            cnt_d      = hdr_cnt;
            csum_clear = 1'b1;
            state_d    = StAddr;
          end
        end
        StAddr: begin
          addr_d  = bus.in_data[ADDR_W-1:0];
          state_d = StData;
        end
        StData: begin
          s1_vld_d  = 1'b1;
          s1_tgt_d  = tgt_q;
          s1_addr_d = addr_q;
          s1_data_d = bus.in_data;
          addr_d    = addr_q + 1'b1;
          cnt_d     = cnt_q - 1'b1;
          csum_add  = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = StCsum;
        end
        StCsum: begin
          if (csum_match) begin
            state_d = StHdr;
          end else begin
            err_code_d = ERR_CSUM;
            state_d    = StErr;
          end
        end
        default: ;
      endcase
    end

    rdy_d = (state_d inside {StHdr, StAddr, StData, StCsum});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHdr;
      tgt_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      rdy_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      words_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_tgt_q   <= '0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rdy_q      <= rdy_d;
      err_code_q <= err_code_d;
      words_q    <= words_d;
      s1_vld_q   <= s1_vld_d;
      s1_tgt_q   <= s1_tgt_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_run      = (state_q == StRun);
  assign err          = (state_q == StErr);
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

endmodule
